// File: rtl/feedback_path_emulator_pkg.sv
// Shared types and helpers for the feedback path emulator.
// Holds the default sample width, the sample type, the unity Q1.7 gain and a saturator.
package feedback_emu_pkg;

   localparam int DATA_W_DEF = 8;

   typedef logic signed [DATA_W_DEF-1:0] sample_t;

   localparam logic [7:0] GAIN_UNITY = 8'h80;

   localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
   localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

   // The value fits when the top three bits of the widened sum agree.
   function automatic sample_t sat_sample(
      input logic signed [DATA_W_DEF+1:0] s
   );
      logic [2:0] top;
      top = s[DATA_W_DEF+1:DATA_W_DEF-1];
      if (top == 3'b000 || top == 3'b111) begin
         return s[DATA_W_DEF-1:0];
      end else if (s[DATA_W_DEF+1]) begin
         return SAMPLE_MIN;
      end else begin
         return SAMPLE_MAX;
      end
   endfunction

endpackage

// File: rtl/feedback_path_emulator_if.sv
// Sample bus between the feedback emulator and its driver.
// master drives strobe/samples/delay/gain/clear; slave returns mic sample, valid, clip.
// o_clip_cnt exists only when FBEMU_CLIP_CNT_EN is defined.
interface feedback_path_emulator_if #(
   parameter int DATA_W = 8,
   parameter int DLY_W  = 6
);
   logic                     i_ce;
   logic signed [DATA_W-1:0] i_data;
   logic signed [DATA_W-1:0] i_spk;
   logic [DLY_W-1:0]         i_delay;
   logic [7:0]               i_gain;
   logic                     i_clip_clr;
   logic signed [DATA_W-1:0] o_data;
   logic                     o_valid;
   logic                     o_clip;
`ifdef FBEMU_CLIP_CNT_EN
   logic [15:0]              o_clip_cnt;
`endif

   modport master (
      output i_ce, i_data, i_spk, i_delay, i_gain, i_clip_clr,
      input  o_data, o_valid, o_clip
`ifdef FBEMU_CLIP_CNT_EN
      , o_clip_cnt
`endif
   );

   modport slave (
      input  i_ce, i_data, i_spk, i_delay, i_gain, i_clip_clr,
      output o_data, o_valid, o_clip
`ifdef FBEMU_CLIP_CNT_EN
      , o_clip_cnt
`endif
   );

endinterface

// File: rtl/fbemu_delay_line.sv
// Circular echo buffer: reads spk(n-d) before writing spk(n), zero until d samples exist.
// Ports: i_clk, i_reset_n (sync, low), i_ce, i_spk, i_delay -> o_echo (combinational).
module fbemu_delay_line #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int DLY_W  = $clog2(DEPTH)
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_ce,
   input  logic signed [DATA_W-1:0] i_spk,
   input  logic [DLY_W-1:0]         i_delay,
   output logic signed [DATA_W-1:0] o_echo
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);

   logic signed [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] wr_ptr_d;
   logic [AW-1:0] fill_q;
   logic [AW-1:0] fill_d;
   logic [AW-1:0] dly;
   logic [AW-1:0] rd_ptr;

   always_comb begin
      // A zero delay would read the slot about to be written.
      dly = (i_delay == '0) ? AW'(1) : AW'(i_delay);
      rd_ptr = wr_ptr_q - dly;
      o_echo = (dly > fill_q) ? '0 : mem_q[rd_ptr];
      wr_ptr_d = wr_ptr_q;
      fill_d = fill_q;
      if (i_ce) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (fill_q != FILL_MAX) begin
            fill_d = fill_q + AW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         fill_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q <= fill_d;
      end
   end

   // Storage is not reset; the fill counter masks stale entries.
   always_ff @(posedge i_clk) begin
      if (i_reset_n && i_ce) begin
         mem_q[wr_ptr_q] <= i_spk;
      end
   end

endmodule

// File: rtl/feedback_path_emulator.sv
// Acoustic loop model: mic = sat(talker + (delayed speaker * Q1.7 gain) >>> 7).
// Ports: i_clk, i_reset_n (sync, low), bus (slave); FBEMU_CLIP_CNT_EN adds o_clip_cnt.
module feedback_path_emulator
   import feedback_emu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 64,
   parameter int DLY_W  = $clog2(DEPTH)
) (
   input logic i_clk,
   input logic i_reset_n,
   feedback_path_emulator_if.slave bus
);

   logic signed [DATA_W-1:0] echo;
   logic signed [DATA_W+8:0] prod;
   logic signed [DATA_W+8:0] prod_sh;
   logic signed [DATA_W+1:0] scaled;
   logic signed [DATA_W+1:0] sum;
   logic signed [DATA_W-1:0] sat_val;
   logic                     ovf;
   logic                     unused_hi;

   logic signed [DATA_W-1:0] o_data_q;
   logic signed [DATA_W-1:0] o_data_d;
   logic                     o_valid_q;
   logic                     o_valid_d;
   logic                     clip_q;
   logic                     clip_d;

   fbemu_delay_line #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .DLY_W  (DLY_W)
   ) u_dly (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_ce      (bus.i_ce),
      .i_spk     (bus.i_spk),
      .i_delay   (bus.i_delay),
      .o_echo    (echo)
   );

   always_comb begin
      prod = echo * $signed({1'b0, bus.i_gain});
      prod_sh = prod >>> 7;
      // |scaled| < 2^DATA_W, so the low DATA_W+2 bits hold it exactly.
      scaled = prod_sh[DATA_W+1:0];
      sum = {{2{bus.i_data[DATA_W-1]}}, bus.i_data} + scaled;
      ovf = (sum[DATA_W+1:DATA_W-1] != 3'b000) &&
            (sum[DATA_W+1:DATA_W-1] != 3'b111);
   end

   assign unused_hi = ^prod_sh[DATA_W+8:DATA_W+2];

   generate
      if (DATA_W == DATA_W_DEF) begin : g_pkg_sat
         assign sat_val = sat_sample(sum);
      end else begin : g_gen_sat
         always_comb begin
            sat_val = sum[DATA_W-1:0];
            if (ovf) begin
               sat_val = sum[DATA_W+1] ?
                  {1'b1, {(DATA_W-1){1'b0}}} :
                  {1'b0, {(DATA_W-1){1'b1}}};
            end
         end
      end
   endgenerate

   always_comb begin
      o_valid_d = bus.i_ce;
      o_data_d = o_data_q;
      clip_d = clip_q;
      if (bus.i_ce) begin
         o_data_d = sat_val;
      end
      if (bus.i_clip_clr) begin
         clip_d = 1'b0;
      end
      if (bus.i_ce && ovf) begin
         clip_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_data_q <= '0;
         o_valid_q <= 1'b0;
         clip_q <= 1'b0;
      end else begin
         o_data_q <= o_data_d;
         o_valid_q <= o_valid_d;
         clip_q <= clip_d;
      end
   end

   assign bus.o_data = o_data_q;
   assign bus.o_valid = o_valid_q;
   assign bus.o_clip = clip_q;

`ifdef FBEMU_CLIP_CNT_EN
   logic [15:0] clip_cnt_q;
   logic [15:0] clip_cnt_d;

   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if (bus.i_clip_clr) begin
         clip_cnt_d = (bus.i_ce && ovf) ? 16'd1 : 16'd0;
      end else if (bus.i_ce && ovf && clip_cnt_q != 16'hFFFF) begin
         clip_cnt_d = clip_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         clip_cnt_q <= '0;
      end else begin
         clip_cnt_q <= clip_cnt_d;
      end
   end

   assign bus.o_clip_cnt = clip_cnt_q;
`endif

endmodule
